spi_flash_rd_ctrl: RTL and testbench

Command sequencer that sits directly upstream of the mode-0 SPI byte driver and issues serial-flash READ transactions through it. It accepts a user read request (start address, byte count). It drives the driver's spi_start/spi_end/data_send and consumes its send_done/rec_done/data_rec/spi_cs. It returns the payload bytes as a valid-qualified stream.

---
 rtl/spi_flash_rd_ctrl.sv | 172 +++++++++++++++++
 tb/tb_spi_flash_rd_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : spi_flash_rd_ctrl
//  Purpose  : Serial-flash READ command sequencer sitting directly upstream of
//             a mode-0 SPI byte driver. A user request (start address, byte
//             count) is turned into the byte stream
//               CMD_READ, A[23:16], A[15:8], A[7:0], rd_len x 8'h00
//             and the bytes clocked back during the payload phase are
//             returned as a valid-qualified stream.
//
//  Ports    : sys_clk / sys_rst_n   clock, synchronous active-low reset
//             rd_req/rd_addr/rd_len request strobe and its arguments
//             rd_busy               request in progress
//             rd_data/rd_valid      payload byte stream
//             rd_done               request-complete pulse
//             spi_start/spi_end     open / close pulses to the byte driver
//             data_send             byte presented to the byte driver
//             send_done/rec_done    byte driver tx-launched / rx-complete
//             data_rec              byte driver received byte
//             spi_cs                byte driver chip select (1 = idle)
//
//  Revision : 1.0  initial release
// ============================================================================
module spi_flash_rd_ctrl #(
    parameter logic [7:0] CMD_READ = 8'h03,
    parameter int         ADDR_W   = 24,
    parameter int         LEN_W    = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [LEN_W-1:0]  rd_len,
    output logic              rd_busy,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic              rd_done,
    output logic              spi_start,
    output logic              spi_end,
    output logic [7:0]        data_send,
    input  logic              send_done,
    input  logic              rec_done,
    input  logic [7:0]        data_rec,
    input  logic              spi_cs
);

    // Byte indices span rd_len + 4 bytes; three spare bits keep the largest
    // transfer from wrapping.
    localparam int IDX_W = LEN_W + 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        XFER    = 2'd1,
        WAIT_CS = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  addr_q;
    logic [LEN_W-1:0]   len_q;
    logic [IDX_W-1:0]   tx_idx;
    logic [IDX_W-1:0]   rx_idx;

    logic [IDX_W-1:0]   last_idx;
    logic [IDX_W-1:0]   tx_nxt;
    logic [7:0]         next_byte;

    // Index of the final byte of the transaction (N - 1 = rd_len + 3).
    assign last_idx = {3'b000, len_q} + IDX_W'(3);

    // Byte that follows the one currently in flight: three address bytes
    // MSB first, then dummy zeros for the payload phase.
    always_comb begin
        tx_nxt    = tx_idx + IDX_W'(1);
        next_byte = 8'h00;
        if (tx_nxt == IDX_W'(1)) begin
            next_byte = addr_q[ADDR_W-1 -: 8];
        end else if (tx_nxt == IDX_W'(2)) begin
            next_byte = addr_q[ADDR_W-9 -: 8];
        end else if (tx_nxt == IDX_W'(3)) begin
            next_byte = addr_q[7:0];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            // Abort without spi_end: the driver shares this reset and
            // releases chip select on its own.
            state     <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            tx_idx    <= '0;
            rx_idx    <= '0;
            rd_busy   <= 1'b0;
            rd_data   <= 8'h00;
            rd_valid  <= 1'b0;
            rd_done   <= 1'b0;
            spi_start <= 1'b0;
            spi_end   <= 1'b0;
            data_send <= 8'h00;
        end else begin
            spi_start <= 1'b0;
            spi_end   <= 1'b0;
            rd_valid  <= 1'b0;
            rd_done   <= 1'b0;

            case (state)
                IDLE: begin
                    if (rd_req) begin
                        if (rd_len != '0) begin
                            addr_q    <= rd_addr;
                            len_q     <= rd_len;
                            tx_idx    <= '0;
                            rx_idx    <= '0;
                            data_send <= CMD_READ;
                            spi_start <= 1'b1;
                            rd_busy   <= 1'b1;
                            state     <= XFER;
                        end else begin
                            // Empty request completes without touching SPI.
                            rd_done   <= 1'b1;
                        end
                    end
                end

                XFER: begin
                    // Next byte is loaded on the edge that sees send_done so
                    // the driver has its MSB well inside its deadline.
                    if (send_done) begin
                        if (tx_idx != last_idx) begin
                            tx_idx    <= tx_nxt;
                            data_send <= next_byte;
                        end else begin
                            spi_end   <= 1'b1;
                        end
                    end
                    // Receive side runs independently of the transmit side;
                    // the first four bytes echo the command/address phase.
                    if (rec_done) begin
                        rx_idx <= rx_idx + IDX_W'(1);
                        if (rx_idx >= IDX_W'(4)) begin
                            rd_data  <= data_rec;
                            rd_valid <= 1'b1;
                        end
                        if (rx_idx == last_idx) begin
                            state <= WAIT_CS;
                        end
                    end
                end

                WAIT_CS: begin
                    if (spi_cs) begin
                        rd_done <= 1'b1;
                        state   <= DONE;
                    end
                end

                DONE: begin
                    // rd_done was raised on entry; busy falls together with it.
                    rd_busy <= 1'b0;
                    state   <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_flash_rd_ctrl
//  Purpose  : Self-checking bench for spi_flash_rd_ctrl. A behavioural SPI
//             byte-driver/flash model answers the sequencer; expected MOSI
//             bytes and payload bytes are queued when a request is issued and
//             checked as the design produces them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_flash_rd_ctrl;

    localparam logic [7:0] CMD = 8'h03;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        rd_req = 1'b0;
    logic [23:0] rd_addr = '0;
    logic [15:0] rd_len = '0;
    logic        rd_busy, rd_valid, rd_done, spi_start, spi_end;
    logic [7:0]  rd_data, data_send;
    logic        send_done = 1'b0, rec_done = 1'b0, spi_cs = 1'b1;
    logic [7:0]  data_rec = 8'h00;

    spi_flash_rd_ctrl #(.CMD_READ(CMD), .ADDR_W(24), .LEN_W(16)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_len    (rd_len),
        .rd_busy   (rd_busy),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_done   (rd_done),
        .spi_start (spi_start),
        .spi_end   (spi_end),
        .data_send (data_send),
        .send_done (send_done),
        .rec_done  (rec_done),
        .data_rec  (data_rec),
        .spi_cs    (spi_cs)
    );

    always #10 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] mosi_exp_q[$];
    logic [7:0] data_exp_q[$];
    logic [7:0] pay [0:511];
    int  cur_n    = 0;
    bit  cur_zero = 1'b0;
    int  n_start  = 0;
    int  n_end    = 0;
    logic rst_seen;

    always @(posedge sys_clk) rst_seen <= sys_rst_n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- byte driver / flash model ----------------
    int  tx_k = 0, rx_k = 0, cnt = 0, blen = 8, post = 0, rx_wait = 0, close_wait = 0;
    bit  active = 1'b0, closing = 1'b0;
    logic [7:0] cur_tx = 8'h00;

    task automatic do_rec();
        rec_done = 1'b1;
        if (rx_k < 4) data_rec = 8'($urandom);
        else          data_rec = pay[rx_k-4];
        rx_k++;
    endtask

    initial begin : slave
        forever begin
            @(negedge sys_clk);
            send_done = 1'b0;
            rec_done  = 1'b0;
            if (!rst_seen) begin
                active = 1'b0; spi_cs = 1'b1; closing = 1'b0; rx_wait = 0; post = 0;
            end else if (!active) begin
                if (spi_start) begin
                    active = 1'b1; spi_cs = 1'b0; tx_k = 0; rx_k = 0;
                    closing = 1'b0; post = 0; rx_wait = 0; cnt = 0;
                    cur_tx = data_send; blen = $urandom_range(8, 12);
                end
            end else begin
                if (rx_wait > 0) begin
                    rx_wait--;
                    if (rx_wait == 0) do_rec();
                end
                if (post == 1) begin
                    // The cycle after send_done: spi_end only after the last byte.
                    chk("spi_end_timing", {31'd0, spi_end}, {31'd0, tx_k == cur_n});
                    post = 0;
                    if (spi_end) begin
                        closing = 1'b1; close_wait = 0;
                    end else begin
                        cur_tx = data_send; cnt = 0; blen = $urandom_range(8, 12);
                    end
                end else if (!closing) begin
                    cnt++;
                    if (cnt == blen) begin
                        send_done = 1'b1;
                        tx_k++;
                        if (mosi_exp_q.size() == 0) chk("extra_mosi_byte", 1, 0);
                        else chk("mosi_byte", {24'd0, cur_tx}, {24'd0, mosi_exp_q.pop_front()});
                        rx_wait = $urandom_range(0, 2);
                        if (rx_wait == 0) do_rec();
                        post = 1;
                    end
                end else if (rx_wait == 0 && rx_k == tx_k) begin
                    close_wait++;
                    if (close_wait >= 2) begin
                        spi_cs = 1'b1; active = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- output monitor / scoreboard ----------------
    initial begin : monitor
        forever begin
            @(posedge sys_clk);
            #1;
            if (sys_rst_n) begin
                if (spi_start) n_start++;
                if (spi_end)   n_end++;
                if (cur_zero)  chk("busy_zero_len", {31'd0, rd_busy}, 0);
                if (rd_valid) begin
                    if (data_exp_q.size() == 0) chk("extra_rd_valid", 1, 0);
                    else chk("rd_data", {24'd0, rd_data}, {24'd0, data_exp_q.pop_front()});
                end
                if (rd_done) begin
                    chk("done_payload_left", data_exp_q.size(), 0);
                    chk("done_mosi_left", mosi_exp_q.size(), 0);
                    chk("done_spi_start_cnt", n_start, cur_zero ? 0 : 1);
                    chk("done_spi_end_cnt", n_end, cur_zero ? 0 : 1);
                    chk("done_busy", {31'd0, rd_busy}, cur_zero ? 0 : 1);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [23:0] a, input int len);
        for (int i = 0; i < 100 && rd_busy; i++) @(negedge sys_clk);
        // Reference: opcode, 3 address bytes MSB first, len dummy zeros.
        mosi_exp_q.push_back(CMD);
        mosi_exp_q.push_back(a[23:16]);
        mosi_exp_q.push_back(a[15:8]);
        mosi_exp_q.push_back(a[7:0]);
        for (int j = 0; j < len; j++) begin
            mosi_exp_q.push_back(8'h00);
            data_exp_q.push_back(pay[j]);
        end
        if (len == 0) mosi_exp_q.delete();
        cur_n = len + 4; cur_zero = (len == 0); n_start = 0; n_end = 0;
        rd_addr = a; rd_len = 16'(len); rd_req = 1'b1;
        @(negedge sys_clk);
        rd_req = 1'b0;
        if (len == 0) begin
            chk("len0_done_latency", {31'd0, rd_done}, 1);
            chk("len0_no_start", {31'd0, spi_start}, 0);
        end else begin
            chk("start_pulse", {31'd0, spi_start}, 1);
            chk("busy_set", {31'd0, rd_busy}, 1);
            chk("start_cmd", {24'd0, data_send}, {24'd0, CMD});
        end
    endtask

    task automatic wait_done(input int len);
        bit got = 1'b0;
        for (int i = 0; i < (len + 4) * 20 + 200 && !got; i++) begin
            @(negedge sys_clk);
            if (rd_done) got = 1'b1;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL done_timeout: got no rd_done expected rd_done for len %0d", len);
        end
    endtask

    task automatic fill_random(input int len);
        for (int j = 0; j < len; j++) pay[j] = 8'($urandom);
    endtask

    initial begin : stim
        repeat (3) @(negedge sys_clk);
        chk("reset_busy", {31'd0, rd_busy}, 0);
        chk("reset_valid", {31'd0, rd_valid}, 0);
        chk("reset_done", {31'd0, rd_done}, 0);
        chk("reset_start", {31'd0, spi_start}, 0);
        chk("reset_end", {31'd0, spi_end}, 0);
        chk("reset_data_send", {24'd0, data_send}, 0);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // 1: two payload bytes
        pay[0] = 8'hA5; pay[1] = 8'h3C;
        issue(24'h123456, 2); wait_done(2);

        // 2: single byte at top of address space
        fill_random(1);
        issue(24'hFFFFFF, 1); wait_done(1);

        // 3: empty request
        repeat (2) @(negedge sys_clk);
        issue(24'h000010, 0);
        repeat (3) @(negedge sys_clk);
        cur_zero = 1'b0;

        // 4: request while busy is ignored; back-to-back request accepted
        fill_random(3);
        issue(24'hABCDEF, 3);
        repeat (10) @(negedge sys_clk);
        rd_addr = 24'h555555; rd_len = 16'd5; rd_req = 1'b1;
        @(negedge sys_clk);
        rd_req = 1'b0;
        wait_done(3);
        fill_random(2);
        issue(24'h0A0B0C, 2); wait_done(2);

        // 5: reset mid-transfer, then a clean request
        fill_random(4);
        issue(24'h424242, 4);
        for (int i = 0; i < 500 && tx_k < 3; i++) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        chk("midrst_busy", {31'd0, rd_busy}, 0);
        chk("midrst_valid", {31'd0, rd_valid}, 0);
        chk("midrst_done", {31'd0, rd_done}, 0);
        chk("midrst_end", {31'd0, spi_end}, 0);
        chk("midrst_data_send", {24'd0, data_send}, 0);
        sys_rst_n = 1'b1;
        mosi_exp_q.delete(); data_exp_q.delete();
        repeat (2) @(negedge sys_clk);
        fill_random(2);
        issue(24'h00FF00, 2); wait_done(2);

        // 6: long transfer, incrementing pattern crossing 255
        for (int j = 0; j < 300; j++) pay[j] = 8'(j);
        issue(24'h010203, 300); wait_done(300);

        // random requests
        for (int k = 0; k < 6; k++) begin
            int l;
            l = $urandom_range(1, 12);
            fill_random(l);
            issue(24'($urandom), l); wait_done(l);
        end

        repeat (5) @(negedge sys_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
